// File: rtl/seq_run_detector.sv
// -----------------------------------------------------------------------------
// seq_run_detector
//
// Moore-style run recogniser for a qualified stream of WIDTH-bit symbols.
// It watches accepted samples (D_valid=1) and tracks how many consecutive
// equal symbols have been seen. When that length reaches RUN_LEN it reports a
// detection. Optionally only runs of one specific value (match_val) count.
//
// Parameters
//   WIDTH    symbol width in bits (>=1)
//   RUN_LEN  consecutive equal accepted samples forming a run (>=2)
//   OVERLAP  1: detection persists and re-fires while the run continues
//            0: run counter restarts at 1 on the sample after a detection
//   CNT_W    width of the saturating detection counter
//
// Ports
//   clock      rising-edge clock for all state
//   reset      synchronous active-high reset, priority over everything
//   D_in       sample symbol
//   D_valid    sample qualifier; D_in is only accepted when high
//   mode       0: run of any value, 1: run of match_val only
//   match_val  target symbol used when mode=1
//   D_out      high while run_cnt == RUN_LEN (state-decoded)
//   det_pulse  registered one-cycle pulse per detection event
//   run_cnt    current run length, saturating at RUN_LEN (0 = no history)
//   det_count  detection events since reset, saturating at all-ones
//
// Every output comes from a register or is decoded from registers only, so
// there is no combinational path from D_in/D_valid/mode to any output.
// -----------------------------------------------------------------------------
module seq_run_detector #(
    parameter int WIDTH   = 1,
    parameter int RUN_LEN = 4,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WIDTH-1:0]                 D_in,
    input  logic                             D_valid,
    input  logic                             mode,
    input  logic [WIDTH-1:0]                 match_val,
    output logic                             D_out,
    output logic                             det_pulse,
    output logic [$clog2(RUN_LEN+1)-1:0]     run_cnt,
    output logic [CNT_W-1:0]                 det_count
);

    localparam int RC_W = $clog2(RUN_LEN + 1);

    localparam logic [RC_W-1:0]  RUN_ZERO = '0;
    localparam logic [RC_W-1:0]  RUN_ONE  = RC_W'(1);
    localparam logic [RC_W-1:0]  RUN_FULL = RC_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // State registers and their next values
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] last_sym_reg;
    logic [WIDTH-1:0] last_sym_next;
    logic [RC_W-1:0]  run_cnt_reg;
    logic [RC_W-1:0]  run_cnt_next;
    logic             det_pulse_reg;
    logic             det_pulse_next;
    logic [CNT_W-1:0] det_count_reg;
    logic [CNT_W-1:0] det_count_next;

    // -------------------------------------------------------------------------
    // Per-bit symbol comparison against the previous accepted symbol and the
    // target value. A symbol is equal when no bit differs.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] diff_last;
    logic [WIDTH-1:0] diff_match;
    logic             same_as_last;
    logic             is_target;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
            assign diff_last[gi]  = D_in[gi] ^ last_sym_reg[gi];
            assign diff_match[gi] = D_in[gi] ^ match_val[gi];
        end
    endgenerate

    assign same_as_last = ~(|diff_last);
    assign is_target    = ~(|diff_match);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        last_sym_next  = last_sym_reg;
        run_cnt_next   = run_cnt_reg;
        det_pulse_next = 1'b0;
        det_count_next = det_count_reg;

        if (D_valid) begin
            last_sym_next = D_in;

            // Rules are evaluated in priority order: a rejected symbol in
            // match mode wipes the history, a fresh or different symbol starts
            // a new run, a full run either stays full or restarts, otherwise
            // the run grows by one.
            if (mode && !is_target) begin
                run_cnt_next = RUN_ZERO;
            end else if ((run_cnt_reg == RUN_ZERO) || !same_as_last) begin
                run_cnt_next = RUN_ONE;
            end else if (run_cnt_reg == RUN_FULL) begin
                if (OVERLAP != 0) begin
                    run_cnt_next = RUN_FULL;
                end else begin
                    run_cnt_next = RUN_ONE;
                end
            end else begin
                run_cnt_next = run_cnt_reg + RUN_ONE;
            end

            // A detection event is any accepted sample that leaves the run
            // full; with overlap this includes every extra equal sample.
            if (run_cnt_next == RUN_FULL) begin
                det_pulse_next = 1'b1;
                if (det_count_reg != CNT_MAX) begin
                    det_count_next = det_count_reg + CNT_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register; reset wins over a coincident valid sample.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            last_sym_reg  <= '0;
            run_cnt_reg   <= RUN_ZERO;
            det_pulse_reg <= 1'b0;
            det_count_reg <= '0;
        end else begin
            last_sym_reg  <= last_sym_next;
            run_cnt_reg   <= run_cnt_next;
            det_pulse_reg <= det_pulse_next;
            det_count_reg <= det_count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign D_out     = (run_cnt_reg == RUN_FULL);
    assign det_pulse = det_pulse_reg;
    assign run_cnt   = run_cnt_reg;
    assign det_count = det_count_reg;

endmodule
